// File: rtl/target_ctl_pkg.sv
// Shared definitions for the target controller: state encodings seen by the
// click detector, LFSR seed/taps, and the position wrap helper.
package target_ctl_pkg;

  // Encodings are fixed by the click detector, which clears its latch on 2'b10.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_ARM    = 2'b10,
    ST_MISS   = 2'b11
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fold a 10-bit random value into [0, max). A single subtraction is enough
  // because legal geometries satisfy 2*max >= 1024.
  function automatic logic [10:0] wrap_pos(input logic [9:0] raw, input logic [10:0] max);
    logic [10:0] ext;
    ext = {1'b0, raw};
    return (ext >= max) ? (ext - max) : ext;
  endfunction

endpackage

// File: rtl/target_ctl_if.sv
// Bus between the target controller and its neighbours (click detector,
// rectangle drawer, frame timing and game start logic).
interface target_ctl_if #(
  parameter int CNT_W = 8
);
  logic             frame_tick;
  logic             start;
  logic             rect_clicked;
  logic [1:0]       state_out;
  logic [10:0]      hstart;
  logic [10:0]      vstart;
  logic [10:0]      hlength;
  logic [10:0]      vlength;
  logic [CNT_W-1:0] hits;
  logic [CNT_W-1:0] misses;
  logic             game_done;

  // Controller side.
  modport master (
    input  frame_tick, start, rect_clicked,
    output state_out, hstart, vstart, hlength, vlength, hits, misses, game_done
  );

  // Environment side.
  modport slave (
    output frame_tick, start, rect_clicked,
    input  state_out, hstart, vstart, hlength, vlength, hits, misses, game_done
  );
endinterface

// File: rtl/target_ctl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the target position source.
module lfsr16
  import target_ctl_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = ^(r_lfsr & LFSR_TAPS);
  assign o_lfsr = r_lfsr;

  // Shift every cycle regardless of game state so positions depend on timing.
  always_ff @(posedge pclk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= {r_lfsr[14:0], w_fb};
  end

endmodule

// File: rtl/target_ctl.sv
// Game-round controller: arms a target at a pseudo-random position, waits for
// a hit or a frame timeout, and tallies hits/misses over a fixed game length.
module target_ctl
  import target_ctl_pkg::*;
#(
  parameter int HRES           = 1024,
  parameter int VRES           = 768,
  parameter int RECT_W         = 64,
  parameter int RECT_H         = 64,
  parameter int TIMEOUT_FRAMES = 120,
  parameter int MISS_FRAMES    = 30,
  parameter int ARM_CYCLES     = 4,
  parameter int ROUNDS         = 16,
  parameter int CNT_W          = 8
) (
  input  logic         pclk,
  input  logic         rst,
  target_ctl_if.master bus
);

  localparam int FRAME_MAX = (TIMEOUT_FRAMES > MISS_FRAMES) ? TIMEOUT_FRAMES : MISS_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam int ARM_W     = $clog2(ARM_CYCLES);
  localparam int RND_W     = $clog2(ROUNDS + 1);

  localparam logic [10:0]        HMAX      = 11'(HRES - RECT_W);
  localparam logic [10:0]        VMAX      = 11'(VRES - RECT_H);
  localparam logic [10:0]        H_CENTER  = 11'((HRES - RECT_W) / 2);
  localparam logic [10:0]        V_CENTER  = 11'((VRES - RECT_H) / 2);
  localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
  localparam logic [FRAME_W-1:0] TO_LAST   = FRAME_W'(TIMEOUT_FRAMES - 1);
  localparam logic [FRAME_W-1:0] MISS_LAST = FRAME_W'(MISS_FRAMES - 1);
  localparam logic [RND_W-1:0]   RND_END   = RND_W'(ROUNDS);

  state_t             r_state;
  logic [10:0]        r_hstart;
  logic [10:0]        r_vstart;
  logic [10:0]        r_hlength;
  logic [10:0]        r_vlength;
  logic [CNT_W-1:0]   r_hits;
  logic [CNT_W-1:0]   r_misses;
  logic               r_done;
  logic [RND_W-1:0]   r_round;
  logic [ARM_W-1:0]   r_arm_cnt;
  logic [FRAME_W-1:0] r_frame_cnt;

  logic [15:0]        w_lfsr;
  logic [10:0]        w_pos_h;
  logic [10:0]        w_pos_v;
  logic [CNT_W-1:0]   w_hits_inc;
  logic [CNT_W-1:0]   w_misses_inc;
  logic [RND_W-1:0]   w_round_inc;

  lfsr16 u_lfsr (
    .pclk   (pclk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );

  // Candidate position from the current LFSR value; only captured on ARM entry.
  assign w_pos_h = wrap_pos(w_lfsr[9:0], HMAX);
  assign w_pos_v = wrap_pos({w_lfsr[3:0], w_lfsr[15:10]}, VMAX);

  assign w_hits_inc   = (r_hits   == '1) ? r_hits   : r_hits   + CNT_W'(1);
  assign w_misses_inc = (r_misses == '1) ? r_misses : r_misses + CNT_W'(1);
  assign w_round_inc  = r_round + RND_W'(1);

  assign bus.state_out = r_state;
  assign bus.hstart    = r_hstart;
  assign bus.vstart    = r_vstart;
  assign bus.hlength   = r_hlength;
  assign bus.vlength   = r_vlength;
  assign bus.hits      = r_hits;
  assign bus.misses    = r_misses;
  assign bus.game_done = r_done;

  // Round FSM plus all registered outputs; a hit takes priority over a timeout.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hstart    <= H_CENTER;
      r_vstart    <= V_CENTER;
      r_hlength   <= 11'(RECT_W);
      r_vlength   <= 11'(RECT_H);
      r_hits      <= '0;
      r_misses    <= '0;
      r_done      <= 1'b0;
      r_round     <= '0;
      r_arm_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_hlength <= 11'(RECT_W);
      r_vlength <= 11'(RECT_H);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state     <= ST_ARM;
            r_hits      <= '0;
            r_misses    <= '0;
            r_round     <= '0;
            r_done      <= 1'b0;
            r_hstart    <= w_pos_h;
            r_vstart    <= w_pos_v;
            r_arm_cnt   <= '0;
            r_frame_cnt <= '0;
          end
        end
        ST_ARM: begin
          r_frame_cnt <= '0;
          if (r_arm_cnt == ARM_LAST) begin
            r_state   <= ST_ACTIVE;
            r_arm_cnt <= '0;
          end else begin
            r_arm_cnt <= r_arm_cnt + ARM_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (bus.rect_clicked) begin
            r_hits  <= w_hits_inc;
            r_round <= w_round_inc;
            if (w_round_inc == RND_END) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_ARM;
              r_hstart    <= w_pos_h;
              r_vstart    <= w_pos_v;
              r_arm_cnt   <= '0;
              r_frame_cnt <= '0;
            end
          end else if (bus.frame_tick) begin
            if (r_frame_cnt == TO_LAST) begin
              r_state     <= ST_MISS;
              r_misses    <= w_misses_inc;
              r_round     <= w_round_inc;
              r_frame_cnt <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
          end
        end
        ST_MISS: begin
          if (bus.frame_tick) begin
            if (r_frame_cnt == MISS_LAST) begin
              r_frame_cnt <= '0;
              if (r_round == RND_END) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= ST_ARM;
                r_hstart  <= w_pos_h;
                r_vstart  <= w_pos_v;
                r_arm_cnt <= '0;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_ctl.sv
// Directed bench for target_ctl: a vector table for short cycle-by-cycle
// behaviour plus hand sequences for timeouts, full games and reset.
module tb_target_ctl;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 pclk = ~pclk;

  target_ctl_if #(.CNT_W(8)) ifc ();

  target_ctl dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (ifc.master)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic       click;
    logic       tick;
    logic [1:0] st;
    logic [7:0] hits;
    logic [7:0] misses;
    logic       done;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic r, s, c, t, input logic [1:0] st,
                              input logic [7:0] h, m, input logic d);
    vec_t v;
    v.rst = r; v.start = s; v.click = c; v.tick = t;
    v.st = st; v.hits = h; v.misses = m; v.done = d;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs for one rising edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic s, input logic c, input logic t);
    rst = r; ifc.start = s; ifc.rect_clicked = c; ifc.frame_tick = t;
    @(posedge pclk);
    #1;
    rst = 1'b0; ifc.start = 1'b0; ifc.rect_clicked = 1'b0; ifc.frame_tick = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    int n = 0;
    while (ifc.state_out !== st && n < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check(name, int'(ifc.state_out), int'(st));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},  int'(ifc.state_out), 0);
    check({tag, "_hstart"}, int'(ifc.hstart), 480);
    check({tag, "_vstart"}, int'(ifc.vstart), 352);
    check({tag, "_hits"},   int'(ifc.hits), 0);
    check({tag, "_misses"}, int'(ifc.misses), 0);
    check({tag, "_done"},   int'(ifc.game_done), 0);
  endtask

  initial begin
    int h0, v0, arm_n;
    ifc.start = 1'b0; ifc.rect_clicked = 1'b0; ifc.frame_tick = 1'b0;

    // Reset then 100 idle cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_vals("idle100");
    check("hlength", int'(ifc.hlength), 64);
    check("vlength", int'(ifc.vlength), 64);

    // Cycle-by-cycle table: ARM length, held start, ARM-time clicks,
    // hit beating a tick, rst beating start, clicks ignored in IDLE.
    vecs[0]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 2'b10, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 2'b10, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 2'b10, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 2'b10, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 2'b01, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 2'b01, 0, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 2'b10, 1, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 2'b10, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 2'b10, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 2'b10, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 2'b01, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 1, 2'b01, 1, 0, 0);
    vecs[14] = mk(0, 0, 1, 1, 2'b10, 2, 0, 0);
    vecs[15] = mk(1, 1, 0, 0, 2'b00, 0, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].click, vecs[i].tick);
      check($sformatf("vec%0d_state", i),  int'(ifc.state_out), int'(vecs[i].st));
      check($sformatf("vec%0d_hits", i),   int'(ifc.hits),      int'(vecs[i].hits));
      check($sformatf("vec%0d_misses", i), int'(ifc.misses),    int'(vecs[i].misses));
      check($sformatf("vec%0d_done", i),   int'(ifc.game_done), int'(vecs[i].done));
    end

    // Start: ARM lasts exactly 4 cycles, position in range and stable.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    h0 = int'(ifc.hstart); v0 = int'(ifc.vstart);
    check("start_hrange", int'(h0 < 960), 1);
    check("start_vrange", int'(v0 < 704), 1);
    arm_n = 0;
    while (ifc.state_out === 2'b10 && arm_n < 20) begin
      arm_n++;
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("arm_len", arm_n, 4);
    check("arm_to_active", int'(ifc.state_out), 1);
    check("stable_h_active", int'(ifc.hstart), h0);
    check("stable_v_active", int'(ifc.vstart), v0);

    // Hit: one-cycle latency to ARM, new position stable through ACTIVE.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("hit_state", int'(ifc.state_out), 2);
    check("hit_hits", int'(ifc.hits), 1);
    h0 = int'(ifc.hstart); v0 = int'(ifc.vstart);
    check("hit_hrange", int'(h0 < 960), 1);
    check("hit_vrange", int'(v0 < 704), 1);
    wait_state(2'b01, 10, "hit_rearm");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("hit_stable_h", int'(ifc.hstart), h0);
    check("hit_stable_v", int'(ifc.vstart), v0);

    // Timeout: 119 ticks stay ACTIVE, 120th enters MISS; 30 ticks back to ARM.
    for (int i = 0; i < 119; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("to_119_state", int'(ifc.state_out), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("to_120_state", int'(ifc.state_out), 3);
    check("to_misses", int'(ifc.misses), 1);
    check("to_hits", int'(ifc.hits), 1);
    for (int i = 0; i < 29; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("miss_29_state", int'(ifc.state_out), 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("miss_30_state", int'(ifc.state_out), 2);

    // Click coincident with the 120th tick: hit wins.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    wait_state(2'b01, 10, "coinc_active");
    for (int i = 0; i < 119; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("coinc_state", int'(ifc.state_out), 2);
    check("coinc_hits", int'(ifc.hits), 1);
    check("coinc_misses", int'(ifc.misses), 0);

    // Full game of 16 hits.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 16; r++) begin
      wait_state(2'b01, 10, $sformatf("game_active%0d", r));
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("game_state", int'(ifc.state_out), 0);
    check("game_done", int'(ifc.game_done), 1);
    check("game_hits", int'(ifc.hits), 16);
    check("game_misses", int'(ifc.misses), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    check("game_idle_hold", int'(ifc.hits), 16);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_state", int'(ifc.state_out), 2);
    check("restart_hits", int'(ifc.hits), 0);
    check("restart_done", int'(ifc.game_done), 0);

    // Reset in the middle of ACTIVE.
    wait_state(2'b01, 10, "rst_active");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    wait_state(2'b01, 10, "rst_active2");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_reset_vals("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/target_ctl.md
Name: target_ctl

Overview:
Game-round controller directly downstream of the click detector. Consumes its latched `rect_clicked` flag and drives the 2-bit state word that the click detector reads back (2'b10 clears its latch). It also supplies the rectangle geometry (hstart/vstart/hlength/vlength) to the click detector and the rectangle-drawing stage. Places each target at a pseudo-random position, times it out, and counts hits and misses over a fixed number of rounds.

Parameters:
HRES, 1024, visible horizontal pixels
VRES, 768, visible vertical pixels
RECT_W, 64, target width in pixels (driven on hlength)
RECT_H, 64, target height in pixels (driven on vlength)
TIMEOUT_FRAMES, 120, frames a target stays ACTIVE before a miss
MISS_FRAMES, 30, frames spent in MISS before re-arming
ARM_CYCLES, 4, pclk cycles spent in ARM (minimum 2)
ROUNDS, 16, targets per game
CNT_W, 8, width of hit/miss counters

Ports:
pclk  in  1  pixel clock
rst  in  1  reset; synchronous, active-high
frame_tick  in  1  one-pclk pulse per frame (vblank start)
start  in  1  level or pulse; starts a game when in IDLE
rect_clicked  in  1  latched click flag from the click detector
state_out  out  2  00 IDLE, 10 ARM, 01 ACTIVE, 11 MISS
hstart  out  11  target left x
vstart  out  11  target top y
hlength  out  11  constant RECT_W
vlength  out  11  constant RECT_H
hits  out  CNT_W  hits in current game, saturating
misses  out  CNT_W  misses in current game, saturating
game_done  out  1  high in IDLE after ROUNDS completed; cleared by start

Behaviour:
- All outputs are registered; every output register uses the synchronous rst.
- Reset values:
  - state_out = 00
  - hstart = (HRES-RECT_W)/2
  - vstart = (VRES-RECT_H)/2
  - hits = 0, misses = 0, game_done = 0
  - internal counters = 0
  - LFSR = 16'hACE1
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every pclk when not in reset, independent of state.
- Position generation (registered on ARM entry only; stable at all other times):
  - raw_h = lfsr[9:0]; HMAX = HRES-RECT_W; hstart = raw_h >= HMAX ? raw_h-HMAX : raw_h.
  - raw_v = {lfsr[3:0], lfsr[15:10]}; VMAX = VRES-RECT_H; vstart likewise with VMAX.
  - Legal parameter sets satisfy 2*HMAX >= 1024 and 2*VMAX >= 1024, so the target always lies fully on screen.
- FSM, one transition per cycle at most:
  - IDLE:
    - start=1 -> ARM.
    - Same cycle: clear hits, misses, round count, game_done; load a new position.
    - Clicks are ignored in IDLE.
  - ARM (drives 10, so the click detector clears its latch):
    - Lasts exactly ARM_CYCLES pclk, then -> ACTIVE.
    - Frame-counter is cleared on entry.
  - ACTIVE:
    - rect_clicked=1 -> hit: hits+1 (saturate), round+1.
      - If the new round count == ROUNDS -> IDLE with game_done=1.
      - Otherwise -> ARM with a new position.
    - Otherwise, frame_tick with frame count == TIMEOUT_FRAMES-1 -> MISS, misses+1 (saturate), round+1.
    - Otherwise, frame_tick increments the frame count.
  - MISS:
    - Counts frame_tick.
    - After MISS_FRAMES ticks: -> IDLE with game_done=1 if round == ROUNDS, else -> ARM with a new position.
- Boundary cases:
  - rect_clicked and timeout in the same cycle: the hit wins.
  - rect_clicked is not sampled in ARM. The detector's output is registered, so it is guaranteed 0 on the first ACTIVE cycle.
  - start held high: only triggers from IDLE; it has no effect in other states.
  - start in the same cycle as rst: rst wins.
  - rst mid-game: immediate return to reset values; state_out=00 on the next edge.
  - round counter width is clog2(ROUNDS+1).
  - Latency from rect_clicked=1 to state_out=10 is one pclk.

Decomposition:
- Shared package: state encodings ST_IDLE/ST_ARM/ST_ACTIVE/ST_MISS (2-bit), LFSR seed and tap constants.
- One natural sub-module: `lfsr16`, the free-running LFSR with sync reset, exposing the 16-bit value.
- The position mapping stays in target_ctl.

Test Plan:
- Reset, then idle 100 cycles -> state_out=00, hstart=480, vstart=352, hits=0, misses=0, game_done=0.
- start pulse -> state_out=10 for exactly 4 pclk, then 01; hstart<960, vstart<704; hlength=vlength=64.
- In ACTIVE, rect_clicked=1 for one cycle -> next cycle state_out=10, hits=1; position changes and stays stable through ACTIVE.
- ACTIVE with no click, 120 frame_ticks -> state_out=11 after the 120th tick, misses=1; after 30 more ticks -> 10.
- rect_clicked=1 coincident with the 120th frame_tick -> hits=1, misses=0, state_out=10.
- 16 hits in a row -> after the 16th, state_out=00, game_done=1, hits=16; next start -> hits=0, game_done=0. Assert rst mid-ACTIVE -> all reset values one edge later.
